// File: rtl/mux_nrr_if.sv
// Handshake bundle for mux_nrr: N producer streams in, one registered stream out.
// master = producer/consumer side (testbench or surrounding logic), slave = the mux itself.
interface mux_nrr_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/mux_nrr.sv
// N-channel registered mux with round-robin / fixed-select arbitration and a one-word output stage.
// Optional 16-bit handshake counter port xfer_cnt when MUX_NRR_XFER_CNT_EN is defined.
module mux_nrr #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_nrr_if.slave    bus
`ifdef MUX_NRR_XFER_CNT_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);
  localparam int SW = $clog2(N);
  typedef logic [SW-1:0] idx_t;

  idx_t         ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  idx_t         out_chan_q, out_chan_d;

  logic         can_load;
  logic         rr_hit;
  idx_t         rr_idx;
  logic         sel_ok;
  logic         rdy_hit;
  idx_t         grant;
  logic [N-1:0] ready_vec;
  logic         xfer;
  logic [31:0]  sel_ext;

  assign can_load = !out_valid_q || bus.out_ready;
  assign sel_ext  = 32'(bus.sel);
  assign sel_ok   = sel_ext < 32'(N);

  // Round-robin search: walk downwards so the candidate closest to ptr is written last and wins.
  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    int cand;
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % N;
      if (bus.in_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = idx_t'(cand);
      end
    end
  end

  // Fixed mode offers ready on sel even without a valid; the transfer still needs in_valid.
  always_comb begin
    grant     = bus.mode ? bus.sel : rr_idx;
    rdy_hit   = bus.mode ? sel_ok : rr_hit;
    ready_vec = '0;
    if (rst_n && can_load && rdy_hit) ready_vec[grant] = 1'b1;
  end

  assign xfer         = |(bus.in_valid & ready_vec);
  assign bus.in_ready = ready_vec;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant)*W +: W];
      out_chan_d  = grant;
      if (!bus.mode) ptr_d = (int'(grant) == N - 1) ? '0 : grant + idx_t'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

`ifdef MUX_NRR_XFER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (out_valid_q && bus.out_ready) cnt_q <= cnt_q + 16'd1;
  end

  assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_mux_nrr.sv
// Self-checking bench for mux_nrr (N=4, W=8): reference arbiter model feeding a scoreboard,
// plus directed scenarios with fixed expected sequences.
module tb_mux_nrr;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nrr_if #(.N(N), .W(W)) bus();

`ifdef MUX_NRR_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  mux_nrr #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUX_NRR_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } word_t;

  word_t       sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_ptr  = 0;
  logic        m_ov   = 1'b0;
  logic [15:0] m_cnt  = '0;

  function automatic int model_ready_idx();
    if (bus.mode) return (int'(bus.sel) < N) ? int'(bus.sel) : -1;
    for (int k = 0; k < N; k++) begin
      if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_cnt = '0;
    sb_q.delete();
  endfunction

  // One clock: check in_ready at negedge, push the predicted word, compare after the edge.
  task automatic step();
    int          ri;
    logic [N-1:0] exp_rdy;
    logic        xf;
    logic        lmode;
    logic        lrdy;
    word_t       w;
    word_t       exp_w;
    @(negedge clk);
    ri      = model_ready_idx();
    exp_rdy = '0;
    if (rst_n && (!m_ov || bus.out_ready) && ri >= 0) exp_rdy[ri] = 1'b1;
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", bus.in_ready, exp_rdy, $time);
    end
    xf = 1'b0;
    if (ri >= 0) xf = exp_rdy[ri] && bus.in_valid[ri];
    if (xf) begin
      w.chan = 2'(ri);
      w.data = bus.in_data[ri*W +: W];
      sb_q.push_back(w);
    end
    if (m_ov && bus.out_ready) m_cnt = m_cnt + 16'd1;
    lmode = bus.mode;
    lrdy  = bus.out_ready;
    @(posedge clk);
    #1;
    if (xf) begin
      m_ov = 1'b1;
      if (!lmode) m_ptr = (ri + 1) % N;
    end else if (m_ov && lrdy) begin
      m_ov = 1'b0;
    end
    checks++;
    if (bus.out_valid !== m_ov) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, m_ov, $time);
    end
    if (xf && sb_q.size() > 0) begin
      exp_w = sb_q.pop_front();
      checks++;
      if (bus.out_chan !== exp_w.chan || bus.out_data !== exp_w.data) begin
        errors++;
        $display("FAIL sb_word: got chan %0d data %h expected chan %0d data %h",
                 bus.out_chan, bus.out_data, exp_w.chan, exp_w.data);
      end
    end
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mode      = 1'($urandom);
      bus.sel       = 2'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      bus.out_ready = 1'($urandom);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_chan !== 2'd0 ||
          bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: got valid %b data %h chan %0d ready %b expected 0/00/0/0000",
                 bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready);
      end
    end
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    bus.mode = 1'b0; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.out_chan !== 2'(exp_seq[k]) || bus.out_data !== 8'(8'hA0 + exp_seq[k])) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got chan %0d data %h expected chan %0d data %h", k,
                 bus.out_chan, bus.out_data, exp_seq[k], 8'(8'hA0 + exp_seq[k]));
      end
    end
  endtask

  task automatic test_sparse();
    int exp_seq[4] = '{1, 3, 1, 3};
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.out_chan !== 2'(exp_seq[k])) begin
        errors++;
        $display("FAIL sparse[%0d]: got chan %0d expected %0d", k, bus.out_chan, exp_seq[k]);
      end
    end
    bus.in_valid = 4'b0100;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd2) begin
      errors++;
      $display("FAIL sparse_single: got valid %b chan %0d expected 1 / 2", bus.out_valid, bus.out_chan);
    end
  endtask

  task automatic test_backpressure();
    set_data(8'hA0, 8'hA1, 8'h5C, 8'hA3);
    bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    set_data(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.out_chan !== 2'd2 ||
          bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure[%0d]: got valid %b data %h chan %0d ready %b expected 1/5c/2/0000",
                 k, bus.out_valid, bus.out_data, bus.out_chan, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd3 || bus.out_data !== 8'hB3) begin
      errors++;
      $display("FAIL bp_release: got valid %b chan %0d data %h expected 1/3/b3",
               bus.out_valid, bus.out_chan, bus.out_data);
    end
  endtask

  task automatic test_fixed();
    set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    bus.mode = 1'b1; bus.sel = 2'd2; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.out_chan !== 2'd2 || bus.out_data !== 8'hC2) begin
        errors++;
        $display("FAIL fixed_sel2[%0d]: got chan %0d data %h expected 2/c2", k, bus.out_chan, bus.out_data);
      end
    end
    bus.sel = 2'd3; bus.in_valid = 4'b0111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL fixed_idle_ready: got %b expected 1000", bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_no_xfer: got out_valid %b expected 0", bus.out_valid);
    end
    bus.mode = 1'b0; bus.in_valid = 4'hF;
    step();
    checks++;
    if (bus.out_chan !== 2'd0 || bus.out_data !== 8'hC0) begin
      errors++;
      $display("FAIL rr_resume0: got chan %0d data %h expected 0/c0", bus.out_chan, bus.out_data);
    end
    step();
    checks++;
    if (bus.out_chan !== 2'd1 || bus.out_data !== 8'hC1) begin
      errors++;
      $display("FAIL rr_resume1: got chan %0d data %h expected 1/c1", bus.out_chan, bus.out_data);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      bus.mode      = ($urandom_range(0, 3) == 0);
      bus.sel       = 2'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  task automatic test_reset_mid();
    bus.mode = 1'b0; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got valid %b ready %b data %h expected 0/0000/00",
               bus.out_valid, bus.in_ready, bus.out_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef MUX_NRR_XFER_CNT_EN
  task automatic test_counter();
    bus.mode = 1'b0; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    checks++;
    if (xfer_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_start: got %0d expected 0", xfer_cnt);
    end
    for (int k = 0; k < 70001; k++) step();
    checks++;
    if (xfer_cnt !== 16'd4464 || xfer_cnt !== m_cnt) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d expected 4464 (model %0d)", xfer_cnt, m_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (xfer_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cnt_reset: got cnt %0d valid %b expected 0/0", xfer_cnt, bus.out_valid);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_fixed();
    test_random();
    test_reset_mid();
`ifdef MUX_NRR_XFER_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
